// File: rtl/ir_err_pkg.sv
// Shared types and constants for the IR steering-error datapath.
package ir_err_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ERR_W = 17;

  localparam logic signed [ERR_W-1:0] SAT_MAX = 17'sd2047;
  localparam logic signed [ERR_W-1:0] SAT_MIN = -17'sd2048;

  // Left shift applied to channel sel: R0,L0 x1; R1,L1 x2; R2,L2 x4; R3,L3 x8
  localparam logic [7:0][1:0] SHIFT_TAB = {2'd3, 2'd3, 2'd2, 2'd2,
                                           2'd1, 2'd1, 2'd0, 2'd0};

endpackage

// File: rtl/ir_term_sel.sv
// Combinational term generator: picks one IR channel, weights it by position
// and negates left-side channels.
module ir_term_sel
  import ir_err_pkg::*;
(
  input  logic        [2:0]       sel,
  input  logic        [11:0]      ir_r0,
  input  logic        [11:0]      ir_r1,
  input  logic        [11:0]      ir_r2,
  input  logic        [11:0]      ir_r3,
  input  logic        [11:0]      ir_l0,
  input  logic        [11:0]      ir_l1,
  input  logic        [11:0]      ir_l2,
  input  logic        [11:0]      ir_l3,
  output logic signed [ERR_W-1:0] term
);

  logic        [11:0]      raw;
  logic signed [ERR_W-1:0] mag;

  always_comb begin
    raw = 12'd0;
    case (sel)
      3'd0: raw = ir_r0;
      3'd1: raw = ir_l0;
      3'd2: raw = ir_r1;
      3'd3: raw = ir_l1;
      3'd4: raw = ir_r2;
      3'd5: raw = ir_l2;
      3'd6: raw = ir_r3;
      3'd7: raw = ir_l3;
      default: raw = 12'd0;
    endcase
    mag  = $signed({5'd0, raw}) <<< SHIFT_TAB[sel];
    term = sel[0] ? -mag : mag;
  end

endmodule

// File: rtl/ir_err_compute.sv
// Position-weighted IR steering error, one channel per clock through a shared
// adder. Build option: IR_ERR_SAT_EN clips the result to [-2048, +2047].
module ir_err_compute
  import ir_err_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    IR_vld,
  input  logic                    line_present,
  input  logic        [11:0]      IR_R0,
  input  logic        [11:0]      IR_R1,
  input  logic        [11:0]      IR_R2,
  input  logic        [11:0]      IR_R3,
  input  logic        [11:0]      IR_L0,
  input  logic        [11:0]      IR_L1,
  input  logic        [11:0]      IR_L2,
  input  logic        [11:0]      IR_L3,
  output logic signed [ERR_W-1:0] error,
  output logic                    err_vld,
  output logic                    line_lost,
  output logic                    busy
);

  state_t                  state;
  logic        [2:0]       sel;
  logic signed [ERR_W-1:0] acc;
  logic signed [ERR_W-1:0] term;

  function automatic logic signed [ERR_W-1:0] clip(input logic signed [ERR_W-1:0] a);
`ifdef IR_ERR_SAT_EN
    if (a > SAT_MAX)      return SAT_MAX;
    else if (a < SAT_MIN) return SAT_MIN;
    else                  return a;
`else
    return a;
`endif
  endfunction

  ir_term_sel u_term_sel (
    .sel   (sel),
    .ir_r0 (IR_R0),
    .ir_r1 (IR_R1),
    .ir_r2 (IR_R2),
    .ir_r3 (IR_R3),
    .ir_l0 (IR_L0),
    .ir_l1 (IR_L1),
    .ir_l2 (IR_L2),
    .ir_l3 (IR_L3),
    .term  (term)
  );

  // acc cannot overflow: worst case magnitude is 4095 * 15 = 61425
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 3'd0;
      acc       <= '0;
      error     <= '0;
      err_vld   <= 1'b0;
      line_lost <= 1'b0;
    end else begin
      err_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (IR_vld) begin
            acc   <= '0;
            sel   <= 3'd0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc + term;
          sel <= sel + 3'd1;
          if (sel == 3'd7) state <= DONE;
        end
        DONE: begin
          error     <= clip(acc);
          line_lost <= ~line_present;
          err_vld   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ir_err_compute.sv
// Directed self-checking bench for ir_err_compute; expected errors are
// hand-computed weighted sums of the applied readings.
module tb_ir_err_compute;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               IR_vld = 1'b0;
  logic               line_present = 1'b1;
  logic        [11:0] IR_R0 = '0, IR_R1 = '0, IR_R2 = '0, IR_R3 = '0;
  logic        [11:0] IR_L0 = '0, IR_L1 = '0, IR_L2 = '0, IR_L3 = '0;
  logic signed [16:0] error;
  logic               err_vld;
  logic               line_lost;
  logic               busy;

  int n_cmp  = 0;
  int n_fail = 0;

  int                 vld_cnt, vld_at, busy_cnt;
  logic signed [16:0] got_err, exp_err;
  logic               got_lost;

  ir_err_compute dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IR_vld       (IR_vld),
    .line_present (line_present),
    .IR_R0        (IR_R0),
    .IR_R1        (IR_R1),
    .IR_R2        (IR_R2),
    .IR_R3        (IR_R3),
    .IR_L0        (IR_L0),
    .IR_L1        (IR_L1),
    .IR_L2        (IR_L2),
    .IR_L3        (IR_L3),
    .error        (error),
    .err_vld      (err_vld),
    .line_lost    (line_lost),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic set_ir(input logic [11:0] r0, r1, r2, r3, l0, l1, l2, l3);
    IR_R0 = r0; IR_R1 = r1; IR_R2 = r2; IR_R3 = r3;
    IR_L0 = l0; IR_L1 = l1; IR_L2 = l2; IR_L3 = l3;
  endtask

  // Pulse IR_vld for one cycle, then watch 14 cycles; i counts edges after the sampling edge.
  task automatic run_calc();
    @(posedge clk); #1 IR_vld = 1'b1;
    @(posedge clk); #1 IR_vld = 1'b0;
    busy_cnt = busy ? 1 : 0;
    vld_cnt  = 0;
    vld_at   = -1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (err_vld) begin
        vld_cnt++;
        if (vld_at < 0) vld_at = i;
        got_err  = error;
        got_lost = line_lost;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (error !== 17'sd0) begin n_fail++; $display("FAIL reset_error: got %0d want 0", error); end
    n_cmp++; if (err_vld !== 1'b0) begin n_fail++; $display("FAIL reset_err_vld: got %b want 0", err_vld); end
    n_cmp++; if (line_lost !== 1'b0) begin n_fail++; $display("FAIL reset_line_lost: got %b want 0", line_lost); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_latency();
    set_ir(0, 0, 0, 0, 0, 0, 0, 0);
    run_calc();
    n_cmp++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL zero_vld_count: got %0d want 1", vld_cnt); end
    n_cmp++; if (vld_at !== 9) begin n_fail++; $display("FAIL zero_latency: got %0d want 9", vld_at); end
    n_cmp++; if (busy_cnt !== 9) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 9", busy_cnt); end
    n_cmp++; if (got_err !== 17'sd0) begin n_fail++; $display("FAIL zero_error: got %0d want 0", got_err); end
    n_cmp++; if (got_lost !== 1'b0) begin n_fail++; $display("FAIL zero_line_lost: got %b want 0", got_lost); end
  endtask

  task automatic test_vector(input string name, input logic [11:0] r0, r1, r2, r3,
                             l0, l1, l2, l3, input int exp_raw, input int exp_sat);
    set_ir(r0, r1, r2, r3, l0, l1, l2, l3);
`ifdef IR_ERR_SAT_EN
    exp_err = 17'(exp_sat);
`else
    exp_err = 17'(exp_raw);
`endif
    run_calc();
    n_cmp++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL %s_vld_count: got %0d want 1", name, vld_cnt); end
    n_cmp++; if (got_err !== exp_err) begin n_fail++; $display("FAIL %s_error: got %0d want %0d", name, got_err, exp_err); end
  endtask

  task automatic test_hold_between();
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (error !== exp_err) begin n_fail++; $display("FAIL hold_error: got %0d want %0d", error, exp_err); end
    n_cmp++; if (err_vld !== 1'b0) begin n_fail++; $display("FAIL hold_err_vld: got %b want 0", err_vld); end
  endtask

  // Second IR_vld sampled at the 4th CALC edge must not restart or queue.
  task automatic test_back_to_back();
    set_ir(12'h000, 12'h123, 12'h010, 12'h000, 0, 0, 0, 0);
    @(posedge clk); #1 IR_vld = 1'b1;
    @(posedge clk); #1 IR_vld = 1'b0;
    vld_cnt = 0; vld_at = -1;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      IR_vld = (i == 3);
      if (err_vld) begin
        vld_cnt++;
        if (vld_at < 0) vld_at = i;
        got_err = error;
      end
    end
    n_cmp++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL b2b_vld_count: got %0d want 1", vld_cnt); end
    n_cmp++; if (vld_at !== 9) begin n_fail++; $display("FAIL b2b_latency: got %0d want 9", vld_at); end
    n_cmp++; if (got_err !== 17'sd646) begin n_fail++; $display("FAIL b2b_error: got %0d want 646", got_err); end
  endtask

  // IR_vld sampled at the DONE->IDLE edge must be ignored.
  task automatic test_vld_at_done();
    set_ir(12'h005, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 IR_vld = 1'b1;
    @(posedge clk); #1 IR_vld = 1'b0;
    vld_cnt = 0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      IR_vld = (i == 8);
      if (err_vld) vld_cnt++;
    end
    n_cmp++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL done_vld_count: got %0d want 1", vld_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_line_lost();
    set_ir(12'h010, 0, 0, 0, 0, 0, 0, 0);
    line_present = 1'b0;
    run_calc();
    n_cmp++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL lost_vld_count: got %0d want 1", vld_cnt); end
    n_cmp++; if (got_err !== 17'sd16) begin n_fail++; $display("FAIL lost_error: got %0d want 16", got_err); end
    n_cmp++; if (got_lost !== 1'b1) begin n_fail++; $display("FAIL lost_flag: got %b want 1", got_lost); end
    line_present = 1'b1;
  endtask

  task automatic test_reset_mid();
    set_ir(12'h0FF, 12'h0FF, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 IR_vld = 1'b1;
    @(posedge clk); #1 IR_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (error !== 17'sd0) begin n_fail++; $display("FAIL midrst_error: got %0d want 0", error); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (line_lost !== 1'b0) begin n_fail++; $display("FAIL midrst_line_lost: got %b want 0", line_lost); end
    @(posedge clk); #1 rst_n = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (err_vld) vld_cnt++;
    end
    n_cmp++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_vld: got %0d want 0", vld_cnt); end
    // 4*3 - 4*1 = 8
    set_ir(0, 0, 12'h003, 0, 0, 0, 12'h001, 0);
    run_calc();
    n_cmp++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL after_rst_vld_count: got %0d want 1", vld_cnt); end
    n_cmp++; if (vld_at !== 9) begin n_fail++; $display("FAIL after_rst_latency: got %0d want 9", vld_at); end
    n_cmp++; if (got_err !== 17'sd8) begin n_fail++; $display("FAIL after_rst_error: got %0d want 8", got_err); end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_vector("r3_max", 0, 0, 0, 12'hFFF, 0, 0, 0, 0, 32760, 2047);
    test_vector("l3_max", 0, 0, 0, 0, 0, 0, 0, 12'hFFF, -32760, -2048);
    test_vector("l0_l1", 0, 0, 0, 0, 12'h100, 12'h100, 0, 0, -768, -768);
    // 1 - 2 + 6 - 8 + 20 - 24 + 56 - 64 = -15
    test_vector("mixed", 1, 3, 5, 7, 2, 4, 6, 8, -15, -15);
    test_vector("all_right", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 0, 0, 0, 61425, 2047);
    test_vector("all_left", 0, 0, 0, 0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, -61425, -2048);
    test_vector("sat_edge", 12'h7FF, 0, 0, 0, 0, 0, 0, 0, 2047, 2047);
    test_hold_between();
    test_back_to_back();
    test_vld_at_done();
    test_line_lost();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
